dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and access sequencer in front of the single-port data memory. The CPU load/store path and a DMA/debug port both request word accesses; the arbiter grants one per cycle, drives the memory's address/write-enable/write-data lines from a registered access stage, and returns registered read data to the winner. It sits between the core's memory stage and `data_memory`, and is the only driver of the memory's `wr_en`.

## Interface
- `DATA_W`, 32, data width of requests and memory words
- `ADDR_W`, 32, request address width; the address is a word index
- `MEM_DEPTH`, 1024, number of valid words; addresses >= `MEM_DEPTH` are out of range

- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `cpu_req` input 1 — CPU request; hold with `cpu_we`/`cpu_addr`/`cpu_wdata` stable until `cpu_gnt`
- `cpu_we` input 1 — 1 = write, 0 = read
- `cpu_addr` input ADDR_W — word address
- `cpu_wdata` input DATA_W — write data
- `cpu_gnt` output 1 — one-cycle grant pulse; the request is accepted in this cycle
- `cpu_rvalid` output 1 — one-cycle read-response pulse
- `cpu_rdata` output DATA_W — read data, valid while `cpu_rvalid` is high
- `cpu_err` output 1 — one-cycle out-of-range pulse, aligned with the response slot
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata`, `dma_err` — same as the CPU set, for the DMA port
- `mem_addr` output ADDR_W — to memory `addr`
- `mem_wr_en` output 1 — to memory `wr_en`
- `mem_wd` output DATA_W — to memory `WD`
- `mem_rd` input DATA_W — from memory `RD` (combinational read)

## Operation
- The design is a three-stage pipeline:
  - **A**: arbitrate and latch the request.
  - **M**: drive the memory.
  - **R**: register the response.
- **A stage**
  - Each cycle, at most one request is granted.
  - Both requesting: grant goes to the port not granted last (round-robin).
  - One requesting: that port is granted.
  - `last_gnt` resets to DMA, so the CPU wins the first tie.
  - On grant, the port id, `we`, `addr`, `wdata` and a range flag (`addr >= MEM_DEPTH`) are latched into the M register with M-valid set.
- **M stage**
  - When M-valid is set, `mem_addr` = latched addr (or 0 if out of range) and `mem_wd` = latched wdata.
  - `mem_wr_en` = M-valid & we & in-range.
  - When M-valid is clear, `mem_wr_en` = 0, and `mem_addr`/`mem_wd` hold their last values.
  - `mem_wr_en` is never high during a read; the memory returns 0 while written.
- **R stage**
  - For an in-range read, `mem_rd` is captured into the granted port's `rdata`, and that port's `rvalid` pulses next cycle.
  - Out-of-range read: `rvalid` and `err` pulse together, with `rdata` = 0.
  - Out-of-range write: no memory write; `err` pulses in the R slot and `rvalid` stays low.
  - In-range write: no response pulse; `gnt` is the acknowledgement.
- Each port's `rdata` holds its last value between responses.
- There is no stall: the memory completes every access in one cycle, so full throughput is one access per cycle with back-to-back grants allowed.
- A port with `req` low is never granted. A request deasserted before grant is dropped silently.

## Timing
- Request is granted in cycle T (`gnt` combinational from `req` and `last_gnt`, high in T only).
- Memory access happens in T+1.
- Read data: `rvalid`/`rdata`/`err` registered, high in T+2. Read latency from grant is 2 cycles.
- Write data reaches memory in T+1.
- Read-after-write:
  - CPU write granted at T and CPU read of the same address at T+1: the read sees the new data, because the write completes in T+1 and the read accesses in T+2.
  - The same rule holds across ports.
- Both ports requesting continuously: grants alternate every cycle.
- Reset (asynchronous, any time):
  - All of these go to 0: `*_gnt`, `*_rvalid`, `*_rdata`, `*_err`, `mem_addr`, `mem_wr_en`, `mem_wd`, M-valid and R-valid.
  - `last_gnt` goes to DMA.
  - In-flight accesses are discarded with no response after release.
  - A write in M is cut immediately.
- First grant is possible in the first `clk` edge cycle after `rst_n` rises.

## Configuration
- Macro: `DMEM_ARB_CPU_PRIO_EN`.
- Defined:
  - CPU has strict priority; DMA is granted only in cycles with `cpu_req` low.
  - `last_gnt` is still maintained, but it is ignored.
- Undefined: round-robin as described above.
- Pipeline, latency and error behaviour are identical in both builds.

## Test plan
- Reset, then CPU write addr 5 = 0xDEADBEEF at T, CPU read addr 5 at T+1 -> `mem_wr_en` high only in T+1; `cpu_rvalid` in T+3 with `cpu_rdata` = 0xDEADBEEF.
- CPU and DMA both hold read requests (addr 0 and 3, memory preloaded 0x55 and 0x05) -> grants CPU, DMA, CPU, DMA…; responses 0x55 on CPU and 0x05 on DMA, each two cycles after its grant. With `DMEM_ARB_CPU_PRIO_EN`: DMA is never granted while `cpu_req` stays high.
- DMA read addr 1024 -> `dma_gnt`, then two cycles later `dma_rvalid` = 1, `dma_err` = 1, `dma_rdata` = 0; `mem_wr_en` stays 0.
- CPU write addr 2000 -> `cpu_err` pulses at T+2, `cpu_rvalid` stays 0, no `mem_wr_en`; a read of addr 2 still returns 0x02.
- Assert `rst_n` low while a write is in M and a read is in R -> `mem_wr_en` drops immediately, no `rvalid` after release, and the memory word is unchanged.
- `cpu_req` pulsed for one cycle while DMA holds the grant from the previous tie -> CPU granted in that cycle (round-robin), and no response is issued for an ungranted request.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one requester port of dmem_arbiter.
// The requester drives the master side and the arbiter drives the slave side.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter and three-stage access sequencer (A: grant, M: memory, R: response)
// in front of the single-port data memory. DMEM_ARB_CPU_PRIO_EN selects strict CPU priority.
module dmem_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  dmem_arbiter_if.slave     cpu_if,
  dmem_arbiter_if.slave     dma_if,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_en_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i
);

  localparam logic [ADDR_W-1:0] MemDepth = ADDR_W'(MEM_DEPTH);

  typedef enum logic {PortCpu, PortDma} port_e;

  port_e             last_gnt_q, m_port_q;
  logic              m_valid_q, m_we_q, m_oor_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wd_q;
  logic              mem_wr_en_q;
  logic              cpu_rvalid_q, cpu_err_q, dma_rvalid_q, dma_err_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

  logic              cpu_win, cpu_gnt, dma_gnt, any_gnt;
  logic              sel_we, sel_oor;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A stage: grants are combinational and forced low while reset is asserted.
  always_comb begin
`ifdef DMEM_ARB_CPU_PRIO_EN
    cpu_win = 1'b1;
`else
    cpu_win = !dma_if.req || (last_gnt_q == PortDma);
`endif
    cpu_gnt   = rst_ni & cpu_if.req & cpu_win;
    dma_gnt   = rst_ni & dma_if.req & ~cpu_gnt;
    any_gnt   = cpu_gnt | dma_gnt;
    sel_we    = cpu_gnt ? cpu_if.we    : dma_if.we;
    sel_addr  = cpu_gnt ? cpu_if.addr  : dma_if.addr;
    sel_wdata = cpu_gnt ? cpu_if.wdata : dma_if.wdata;
    sel_oor   = sel_addr >= MemDepth;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_gnt_q   <= PortDma;
      m_port_q     <= PortCpu;
      m_valid_q    <= 1'b0;
      m_we_q       <= 1'b0;
      m_oor_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
      mem_wr_en_q  <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
      dma_err_q    <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      // A -> M: latch the winner; memory lines hold their values while M is idle.
      m_valid_q   <= any_gnt;
      mem_wr_en_q <= any_gnt & sel_we & ~sel_oor;
      if (any_gnt) begin
        last_gnt_q <= cpu_gnt ? PortCpu : PortDma;
        m_port_q   <= cpu_gnt ? PortCpu : PortDma;
        m_we_q     <= sel_we;
        m_oor_q    <= sel_oor;
        mem_addr_q <= sel_oor ? '0 : sel_addr;
        mem_wd_q   <= sel_wdata;
      end

      // M -> R: response pulses last one cycle; rdata holds between responses.
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      dma_rvalid_q <= 1'b0;
      dma_err_q    <= 1'b0;
      if (m_valid_q) begin
        if (m_port_q == PortCpu) begin
          cpu_err_q <= m_oor_q;
          if (!m_we_q) begin
            cpu_rvalid_q <= 1'b1;
            cpu_rdata_q  <= m_oor_q ? '0 : mem_rd_i;
          end
        end else begin
          dma_err_q <= m_oor_q;
          if (!m_we_q) begin
            dma_rvalid_q <= 1'b1;
            dma_rdata_q  <= m_oor_q ? '0 : mem_rd_i;
          end
        end
      end
    end
  end

  assign cpu_if.gnt    = cpu_gnt;
  assign cpu_if.rvalid = cpu_rvalid_q;
  assign cpu_if.rdata  = cpu_rdata_q;
  assign cpu_if.err    = cpu_err_q;
  assign dma_if.gnt    = dma_gnt;
  assign dma_if.rvalid = dma_rvalid_q;
  assign dma_if.rdata  = dma_rdata_q;
  assign dma_if.err    = dma_err_q;

  assign mem_addr_o  = mem_addr_q;
  assign mem_wd_o    = mem_wd_q;
  assign mem_wr_en_o = mem_wr_en_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with a 1024-word behavioural memory.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_wr_en;
  logic [31:0] mem [0:1023];
  int          n_vec = 0;
  int          n_miscmp = 0;

  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) cpu_if ();
  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) dma_if ();

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1024)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cpu_if      (cpu_if),
    .dma_if      (dma_if),
    .mem_addr_o  (mem_addr),
    .mem_wr_en_o (mem_wr_en),
    .mem_wd_o    (mem_wd),
    .mem_rd_i    (mem_rd)
  );

  always #5 clk_i = ~clk_i;

  // Memory returns 0 while it is being written.
  assign mem_rd = mem_wr_en ? 32'h0 : mem[mem_addr[9:0]];
  always @(posedge clk_i) if (mem_wr_en) mem[mem_addr[9:0]] <= mem_wd;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    cpu_if.req = req; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata;
  endtask

  task automatic drive_dma(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    dma_if.req = req; dma_if.we = we; dma_if.addr = addr; dma_if.wdata = wdata;
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    cyc();
    rst_ni = 1'b0;
    #1;
    check_eq("rst_cpu_gnt", cpu_if.gnt, 1'b0);
    check_eq("rst_mem_wr_en", mem_wr_en, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_dma_rdata", dma_if.rdata, 32'h0);
    cyc();
    rst_ni = 1'b1;
  endtask

  logic [7:0] rr_cpu, rr_dma;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i;
    mem[0] = 32'h55;
    mem[3] = 32'h05;
    drive_cpu(1'b1, 1'b0, 32'd0, 32'h0);
    drive_dma(1'b1, 1'b0, 32'd3, 32'h0);

    // Reset state with both requests held high.
    #1;
    check_eq("init_cpu_gnt", cpu_if.gnt, 1'b0);
    check_eq("init_dma_gnt", dma_if.gnt, 1'b0);
    check_eq("init_mem_wr_en", mem_wr_en, 1'b0);
    check_eq("init_mem_addr", mem_addr, 32'h0);
    check_eq("init_mem_wd", mem_wd, 32'h0);
    check_eq("init_cpu_rvalid", cpu_if.rvalid, 1'b0);
    check_eq("init_cpu_rdata", cpu_if.rdata, 32'h0);
    check_eq("init_dma_err", dma_if.err, 1'b0);
    drive_cpu(1'b0, 1'b0, 32'd0, 32'h0);
    drive_dma(1'b0, 1'b0, 32'd0, 32'h0);
    cyc();
    rst_ni = 1'b1;

    // Write then read-after-write of addr 5.
    cyc(); drive_cpu(1'b1, 1'b1, 32'd5, 32'hDEADBEEF); #1;
    check_eq("raw_gnt_w", cpu_if.gnt, 1'b1);
    check_eq("raw_dma_gnt", dma_if.gnt, 1'b0);
    check_eq("raw_wr_en_t", mem_wr_en, 1'b0);
    cyc(); drive_cpu(1'b1, 1'b0, 32'd5, 32'h0); #1;
    check_eq("raw_gnt_r", cpu_if.gnt, 1'b1);
    check_eq("raw_wr_en_t1", mem_wr_en, 1'b1);
    check_eq("raw_mem_addr", mem_addr, 32'd5);
    check_eq("raw_mem_wd", mem_wd, 32'hDEADBEEF);
    cyc(); drive_cpu(1'b0, 1'b0, 32'd0, 32'h0); #1;
    check_eq("raw_wr_en_t2", mem_wr_en, 1'b0);
    check_eq("raw_no_wresp", cpu_if.rvalid, 1'b0);
    check_eq("raw_gnt_idle", cpu_if.gnt, 1'b0);
    cyc(); #1;
    check_eq("raw_rvalid", cpu_if.rvalid, 1'b1);
    check_eq("raw_rdata", cpu_if.rdata, 32'hDEADBEEF);
    check_eq("raw_err", cpu_if.err, 1'b0);
    cyc(); #1;
    check_eq("raw_rvalid_drop", cpu_if.rvalid, 1'b0);
    check_eq("raw_rdata_hold", cpu_if.rdata, 32'hDEADBEEF);

    // Both ports hold reads: addr 0 on CPU, addr 3 on DMA.
    do_reset();
`ifdef DMEM_ARB_CPU_PRIO_EN
    rr_cpu = 8'b0011_1111; rr_dma = 8'b0000_0000;
`else
    rr_cpu = 8'b0001_0101; rr_dma = 8'b0010_1010;
`endif
    for (int i = 0; i < 8; i++) begin
      cyc();
      drive_cpu(i < 6, 1'b0, 32'd0, 32'h0);
      drive_dma(i < 6, 1'b0, 32'd3, 32'h0);
      #1;
      check_eq($sformatf("tie_cpu_gnt%0d", i), cpu_if.gnt, rr_cpu[i]);
      check_eq($sformatf("tie_dma_gnt%0d", i), dma_if.gnt, rr_dma[i]);
      if (i >= 2) begin
        check_eq($sformatf("tie_cpu_rv%0d", i), cpu_if.rvalid, rr_cpu[i-2]);
        check_eq($sformatf("tie_dma_rv%0d", i), dma_if.rvalid, rr_dma[i-2]);
        if (rr_cpu[i-2]) check_eq($sformatf("tie_cpu_rd%0d", i), cpu_if.rdata, 32'h55);
        if (rr_dma[i-2]) check_eq($sformatf("tie_dma_rd%0d", i), dma_if.rdata, 32'h05);
      end
    end

    // DMA read out of range.
    cyc(); drive_dma(1'b1, 1'b0, 32'd1024, 32'h0); #1;
    check_eq("oor_r_gnt", dma_if.gnt, 1'b1);
    check_eq("oor_r_cpu_gnt", cpu_if.gnt, 1'b0);
    cyc(); drive_dma(1'b0, 1'b0, 32'd0, 32'h0); #1;
    check_eq("oor_r_wr_en", mem_wr_en, 1'b0);
    check_eq("oor_r_mem_addr", mem_addr, 32'h0);
    cyc(); #1;
    check_eq("oor_r_rvalid", dma_if.rvalid, 1'b1);
    check_eq("oor_r_err", dma_if.err, 1'b1);
    check_eq("oor_r_rdata", dma_if.rdata, 32'h0);
    cyc(); #1;
    check_eq("oor_r_err_drop", dma_if.err, 1'b0);

    // CPU write out of range, then read addr 2.
    cyc(); drive_cpu(1'b1, 1'b1, 32'd2000, 32'h12345678); #1;
    check_eq("oor_w_gnt", cpu_if.gnt, 1'b1);
    cyc(); drive_cpu(1'b1, 1'b0, 32'd2, 32'h0); #1;
    check_eq("oor_w_gnt_r", cpu_if.gnt, 1'b1);
    check_eq("oor_w_wr_en", mem_wr_en, 1'b0);
    cyc(); drive_cpu(1'b0, 1'b0, 32'd0, 32'h0); #1;
    check_eq("oor_w_err", cpu_if.err, 1'b1);
    check_eq("oor_w_rvalid", cpu_if.rvalid, 1'b0);
    check_eq("oor_w_wr_en2", mem_wr_en, 1'b0);
    cyc(); #1;
    check_eq("oor_w_rd_rvalid", cpu_if.rvalid, 1'b1);
    check_eq("oor_w_rd_data", cpu_if.rdata, 32'h02);
    check_eq("oor_w_rd_err", cpu_if.err, 1'b0);

    // Reset with a write in M and a read in R.
    cyc(); drive_dma(1'b1, 1'b0, 32'd3, 32'h0); #1;
    check_eq("rip_dma_gnt", dma_if.gnt, 1'b1);
    cyc(); drive_dma(1'b0, 1'b0, 32'd0, 32'h0); drive_cpu(1'b1, 1'b1, 32'd0, 32'hBAD); #1;
    check_eq("rip_cpu_gnt", cpu_if.gnt, 1'b1);
    cyc(); drive_cpu(1'b0, 1'b0, 32'd0, 32'h0); #1;
    check_eq("rip_wr_en_pre", mem_wr_en, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_eq("rip_wr_en_cut", mem_wr_en, 1'b0);
    check_eq("rip_dma_rvalid", dma_if.rvalid, 1'b0);
    cyc();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check_eq($sformatf("rip_post_cpu_rv%0d", i), cpu_if.rvalid, 1'b0);
      check_eq($sformatf("rip_post_dma_rv%0d", i), dma_if.rvalid, 1'b0);
      check_eq($sformatf("rip_post_err%0d", i), cpu_if.err, 1'b0);
    end
    check_eq("rip_mem0", mem[0], 32'h55);

    // Round-robin with a one-cycle CPU pulse; CPU reads addr 2, DMA reads addr 3.
    do_reset();
`ifdef DMEM_ARB_CPU_PRIO_EN
    rr_cpu = 8'b0011_0101; rr_dma = 8'b0000_1010;
`else
    rr_cpu = 8'b0001_0101; rr_dma = 8'b0010_1010;
`endif
    for (int i = 0; i < 8; i++) begin
      logic [7:0] creq, dreq;
      creq = 8'b0011_0101;
      dreq = 8'b0010_1111;
      cyc();
      drive_cpu(creq[i], 1'b0, 32'd2, 32'h0);
      drive_dma(dreq[i], 1'b0, 32'd3, 32'h0);
      #1;
      check_eq($sformatf("pulse_cpu_gnt%0d", i), cpu_if.gnt, rr_cpu[i]);
      check_eq($sformatf("pulse_dma_gnt%0d", i), dma_if.gnt, rr_dma[i]);
      if (i >= 2) begin
        check_eq($sformatf("pulse_cpu_rv%0d", i), cpu_if.rvalid, rr_cpu[i-2]);
        check_eq($sformatf("pulse_dma_rv%0d", i), dma_if.rvalid, rr_dma[i-2]);
        if (rr_cpu[i-2]) check_eq($sformatf("pulse_cpu_rd%0d", i), cpu_if.rdata, 32'h02);
        if (rr_dma[i-2]) check_eq($sformatf("pulse_dma_rd%0d", i), dma_if.rdata, 32'h05);
      end
    end
    cyc(); #1;
    check_eq("pulse_tail_cpu_rv", cpu_if.rvalid, rr_cpu[6]);
    check_eq("pulse_tail_dma_rv", dma_if.rvalid, rr_dma[6]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
